beat_sequencer: RTL and testbench

Tempo-driven step sequencer for the piano/drum display path. It owns the slow beat timebase: a programmable divider sets the step period, and a 16-step pattern memory is walked once per step to emit per-voice hit pulses and a step index to the display and sound logic. It adds start/stop control, runtime tempo reconfiguration and a 50 % duty phase output that existing display blinking logic consumes.

---
 rtl/beat_pkg.sv | 18 +
 rtl/tempo_divider.sv | 61 ++++++
 rtl/beat_sequencer.sv | 96 +++++++++
 tb/tb_beat_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Shared types and defaults for the beat sequencer: FSM encoding, pattern geometry
// and tempo divider limits.
package beat_pkg;

  localparam int unsigned STEPS       = 16;
  localparam int unsigned VOICES      = 4;
  localparam int unsigned DIV_W       = 24;
  localparam int unsigned DEFAULT_DIV = 4194304;
  localparam int unsigned MIN_DIV     = 2;
  localparam int unsigned STEP_W      = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

endpackage

// File: rtl/tempo_divider.sv
// Step-period timebase: free-running count within a step, a shadow/active divider
// pair so a step in progress never changes length, and the 50 % phase output.
module tempo_divider #(
  parameter int unsigned DIV_W       = beat_pkg::DIV_W,
  parameter int unsigned DEFAULT_DIV = beat_pkg::DEFAULT_DIV,
  parameter int unsigned MIN_DIV     = beat_pkg::MIN_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             wrap,
  output logic             phase
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] act_q, act_d;

  always_comb begin
    shadow_d = shadow_q;
    if (div_load) begin
      shadow_d = (div_in < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_in;
    end
  end

  assign wrap  = en && (count_q == (act_q - DIV_W'(1)));
  assign phase = en && (count_q < (act_q >> 1));

  // A load in the same cycle as a reload is taken immediately.
  always_comb begin
    count_d = count_q;
    act_d   = act_q;
    if (restart) begin
      count_d = '0;
      act_d   = shadow_d;
    end else if (!en) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
      act_d   = shadow_d;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      shadow_q <= DIV_W'(DEFAULT_DIV);
      act_q    <= DIV_W'(DEFAULT_DIV);
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Tempo-driven 16-step sequencer: start/stop FSM, step counter and pattern register
// file; emits a beat pulse, step index and per-voice hits each step.
module beat_sequencer #(
  parameter int unsigned STEPS       = beat_pkg::STEPS,
  parameter int unsigned VOICES      = beat_pkg::VOICES,
  parameter int unsigned DIV_W       = beat_pkg::DIV_W,
  parameter int unsigned DEFAULT_DIV = beat_pkg::DEFAULT_DIV
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [DIV_W-1:0]         div_in,
  input  logic                     div_load,
  input  logic                     pat_we,
  input  logic [$clog2(STEPS)-1:0] pat_addr,
  input  logic [VOICES-1:0]        pat_data,
  output logic                     beat,
  output logic [$clog2(STEPS)-1:0] step,
  output logic [VOICES-1:0]        hits,
  output logic                     phase,
  output logic                     running
);

  import beat_pkg::*;

  localparam int unsigned SW = $clog2(STEPS);

  state_e            state_q, state_d;
  logic              wrap;
  logic              restart;
  logic              beat_q, beat_d;
  logic [SW-1:0]     step_q, step_d;
  logic [VOICES-1:0] pattern_q [STEPS];

  tempo_divider #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .MIN_DIV     (MIN_DIV)
  ) u_tempo (
    .clk      (clk),
    .reset    (reset),
    .en       (running),
    .restart  (restart),
    .div_in   (div_in),
    .div_load (div_load),
    .wrap     (wrap),
    .phase    (phase)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // stop wins over start; a stop sampled on the last count of a step ends at once.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start && !stop) state_d = RUN;
      RUN:      if (stop) state_d = wrap ? IDLE : STOPPING;
      STOPPING: if (wrap) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Kept outside the output process so the divider's wrap input has no path through state_d.
  assign running = (state_q != IDLE);

  always_comb begin
    restart = (state_q == IDLE) && (state_d == RUN);
    beat_d  = restart || ((state_q == RUN) && (state_d == RUN) && wrap);
    step_d  = step_q;
    if ((state_d == IDLE) || restart) step_d = '0;
    else if (beat_d)                  step_d = step_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= 1'b0;
      step_q <= '0;
      for (int unsigned i = 0; i < STEPS; i++) pattern_q[i] <= '0;
    end else begin
      beat_q <= beat_d;
      step_q <= step_d;
      if (pat_we) pattern_q[pat_addr] <= pat_data;
    end
  end

  // Read straight from the array so a write lands for any later beat, while a write
  // in the beat cycle itself leaves this beat's hits unchanged.
  assign beat = beat_q;
  assign step = step_q;
  assign hits = beat_q ? pattern_q[step_q] : '0;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: expected beats are queued as stimulus is
// driven and checked by a monitor on the falling edge.
module tb_beat_sequencer;

  localparam int unsigned DIV_W = 24;
  localparam int unsigned DEF   = 12;

  logic             clk = 1'b0;
  logic             reset, start, stop, div_load, pat_we;
  logic [DIV_W-1:0] div_in;
  logic [3:0]       pat_addr, pat_data;
  logic             beat, phase, running;
  logic [3:0]       step, hits;

  typedef struct {
    int         cyc;
    int         stp;
    logic [3:0] h;
  } beat_t;

  beat_t      exp_q[$];
  logic [3:0] model [16];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;

  beat_sequencer #(
    .STEPS       (16),
    .VOICES      (4),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .div_in   (div_in),
    .div_load (div_load),
    .pat_we   (pat_we),
    .pat_addr (pat_addr),
    .pat_data (pat_data),
    .beat     (beat),
    .step     (step),
    .hits     (hits),
    .phase    (phase),
    .running  (running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load_div(input int d);
    div_in   = DIV_W'(d);
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  task automatic push_beats(input int first_cyc, input int first_step, input int n, input int div);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.cyc = first_cyc + k * div;
      b.stp = (first_step + k) % 16;
      b.h   = model[b.stp];
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (beat) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", 32'(step), 32'hffff_ffff);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_cyc", cyc, e.cyc);
          check("beat_step", 32'(step), 32'(e.stp));
          check("beat_hits", 32'(hits), 32'(e.h));
        end
      end else begin
        check("hits_off", 32'(hits), 32'd0);
      end
    end
  end

  initial begin
    int n;
    int t3 [7];
    reset = 1'b1; start = 1'b0; stop = 1'b0; div_load = 1'b0; pat_we = 1'b0;
    div_in = '0; pat_addr = '0; pat_data = '0;
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    check("rst_beat", 32'(beat), 0);
    check("rst_step", 32'(step), 0);
    check("rst_hits", 32'(hits), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_running", 32'(running), 0);

    // Period 8: beats every 8 cycles, phase 4 high / 4 low, stop at count 2.
    load_div(8);
    n = cyc;
    start = 1'b1;
    push_beats(n + 1, 0, 3, 8);
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("phase8", 32'(phase), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    wait_until(n + 19);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_until(n + 24);
    check("stop_run_hi", 32'(running), 1);
    tick();
    check("stop_run_lo", 32'(running), 0);
    check("stop_step", 32'(step), 0);

    // Pattern hits and 15 -> 0 wrap at period 4.
    pat_we = 1'b1; pat_addr = 4'd3; pat_data = 4'b1010;
    tick();
    pat_addr = 4'd0; pat_data = 4'b0001;
    tick();
    pat_we = 1'b0;
    model[3] = 4'b1010;
    model[0] = 4'b0001;
    load_div(4);
    n = cyc;
    start = 1'b1;
    push_beats(n + 1, 0, 17, 4);
    tick();
    start = 1'b0;
    wait_until(n + 66);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_until(n + 68);
    check("t2_run_hi", 32'(running), 1);
    tick();
    check("t2_run_lo", 32'(running), 0);

    // Mid-step reloads: 8 -> 5 -> clamp(0)=2, then start+stop together.
    load_div(8);
    n = cyc;
    t3 = '{1, 9, 14, 19, 24, 26, 28};
    for (int k = 0; k < 7; k++) begin
      beat_t b;
      b.cyc = n + t3[k];
      b.stp = k;
      b.h   = model[k];
      exp_q.push_back(b);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(n + 3);
    load_div(5);
    wait_until(n + 10);
    check("phase5_hi", 32'(phase), 1);
    tick();
    check("phase5_lo", 32'(phase), 0);
    wait_until(n + 20);
    load_div(0);
    wait_until(n + 28);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t3_run_hi", 32'(running), 1);
    tick();
    check("t3_run_lo", 32'(running), 0);
    check("t3_step", 32'(step), 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("idle_both_run", 32'(running), 0);
    check("idle_both_beat", 32'(beat), 0);

    // Writes during play: beat-cycle write is deferred, pre-beat write is seen.
    load_div(4);
    n = cyc;
    push_beats(n + 1, 0, 1, 4);
    model[0] = 4'b0110;
    model[2] = 4'b1111;
    push_beats(n + 5, 1, 16, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    pat_we = 1'b1; pat_addr = 4'd0; pat_data = 4'b0110;
    tick();
    pat_we = 1'b0;
    wait_until(n + 8);
    pat_we = 1'b1; pat_addr = 4'd2; pat_data = 4'b1111;
    tick();
    pat_we = 1'b0;
    wait_until(n + 65);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_until(n + 68);
    check("t4_run_hi", 32'(running), 1);
    tick();
    check("t4_run_lo", 32'(running), 0);

    // Reset in STOPPING restores defaults and clears the pattern.
    load_div(6);
    n = cyc;
    push_beats(n + 1, 0, 1, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("stopping_run", 32'(running), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_beat", 32'(beat), 0);
    check("rst2_step", 32'(step), 0);
    check("rst2_hits", 32'(hits), 0);
    check("rst2_phase", 32'(phase), 0);
    check("rst2_running", 32'(running), 0);
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    n = cyc;
    push_beats(n + 1, 0, 2, DEF);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(n + 6);
    check("phase12_hi", 32'(phase), 1);
    tick();
    check("phase12_lo", 32'(phase), 0);
    wait_until(n + 13);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_until(n + 24);
    check("t5_run_hi", 32'(running), 1);
    tick();
    check("t5_run_lo", 32'(running), 0);

    repeat (4) tick();
    check("beats_missing", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
